// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Round-robin sharing of one W-bit two's-complement adder between NREQ
//   requesters. One operand pair is forwarded at a time over the adder
//   valid/ack handshake; the result returns to the winner with a one-cycle
//   req_ack strobe. All outputs are registered.
//
//   Optional build macro: ADDER_ARB_TIMEOUT_EN
//     defined     - a 10-bit watchdog aborts a transaction after TO_CYC
//                   ISSUE cycles without Adder_ack (rsp_exc = 2'b11).
//     not defined - ISSUE waits indefinitely for Adder_ack.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no transaction; arbitrate among req_valid from rr_ptr
//   ISSUE | Adder_valid high, operands held, waiting for Adder_ack
//   RESP  | req_ack[g] high for this one cycle; never arbitrated
module adder_share_arbiter #(
  parameter int W    = 25,
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
`ifdef ADDER_ARB_TIMEOUT_EN
  ,
  parameter int TO_CYC = 64
`endif
) (
  input  logic              CLK,
  input  logic              RSTK,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ack,
  output logic [W-1:0]      rsp_dout,
  output logic              rsp_cout,
  output logic [1:0]        rsp_exc,
  output logic [IDW-1:0]    gnt_id,
  output logic              busy,
  output logic [W-1:0]      Adder_datain1,
  output logic [W-1:0]      Adder_datain2,
  output logic              Adder_valid,
  input  logic [1:0]        Adder_Exc,
  input  logic [W-1:0]      Adder_dataout,
  input  logic              Adder_carryout,
  input  logic              Adder_ack
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  state_t            state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    gnt_q, gnt_d;
  logic [W-1:0]      din1_q, din1_d;
  logic [W-1:0]      din2_q, din2_d;
  logic              avalid_q, avalid_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [W-1:0]      dout_q, dout_d;
  logic              cout_q, cout_d;
  logic [1:0]        exc_q, exc_d;
  logic              busy_q, busy_d;

`ifdef ADDER_ARB_TIMEOUT_EN
  localparam logic [9:0] WDOG_LAST = 10'(TO_CYC - 1);
  logic [9:0]        wdog_q, wdog_d;
`endif

  // Arbitration result: first valid requester at or after rr_ptr, wrapping.
  logic              win_found;
  logic [IDW-1:0]    win_idx;
  logic [IDW:0]      cand;
  logic [W-1:0]      sel_a;
  logic [W-1:0]      sel_b;
  logic [IDW:0]      rr_next;

  // Round-robin scan starting at rr_ptr; candidate index wraps modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(off);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!win_found && req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  // Pointer advance after a completed grant: one past the grantee, wrapping.
  always_comb begin
    rr_next = {1'b0, gnt_q} + (IDW+1)'(1);
    if (rr_next >= NREQ_W) begin
      rr_next = '0;
    end
  end

  // Next-state and registered-output logic; everything holds unless changed.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    din1_d   = din1_q;
    din2_d   = din2_q;
    avalid_d = avalid_q;
    ack_d    = '0;
    dout_d   = dout_q;
    cout_d   = cout_q;
    exc_d    = exc_q;
    busy_d   = busy_q;
`ifdef ADDER_ARB_TIMEOUT_EN
    wdog_d   = wdog_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          din1_d   = sel_a;
          din2_d   = sel_b;
          avalid_d = 1'b1;
          gnt_d    = win_idx;
          busy_d   = 1'b1;
          state_d  = S_ISSUE;
`ifdef ADDER_ARB_TIMEOUT_EN
          wdog_d   = '0;
`endif
        end
      end
      S_ISSUE: begin
        if (Adder_ack) begin
          dout_d   = Adder_dataout;
          cout_d   = Adder_carryout;
          exc_d    = Adder_Exc;
          ack_d    = NREQ'(1) << gnt_q;
          avalid_d = 1'b0;
          din1_d   = '0;
          din2_d   = '0;
          state_d  = S_RESP;
        end
`ifdef ADDER_ARB_TIMEOUT_EN
        // A silent adder is abandoned; the requester sees exception 2'b11.
        else if (wdog_q == WDOG_LAST) begin
          dout_d   = '0;
          cout_d   = 1'b0;
          exc_d    = 2'b11;
          ack_d    = NREQ'(1) << gnt_q;
          avalid_d = 1'b0;
          din1_d   = '0;
          din2_d   = '0;
          state_d  = S_RESP;
        end else begin
          wdog_d   = wdog_q + 10'd1;
        end
`endif
      end
      S_RESP: begin
        // No arbitration here so a requester still showing its old valid
        // during the strobe cycle is not served twice.
        busy_d   = 1'b0;
        rr_ptr_d = rr_next[IDW-1:0];
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RSTK) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      din1_q   <= '0;
      din2_q   <= '0;
      avalid_q <= 1'b0;
      ack_q    <= '0;
      dout_q   <= '0;
      cout_q   <= 1'b0;
      exc_q    <= 2'b00;
      busy_q   <= 1'b0;
`ifdef ADDER_ARB_TIMEOUT_EN
      wdog_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      din1_q   <= din1_d;
      din2_q   <= din2_d;
      avalid_q <= avalid_d;
      ack_q    <= ack_d;
      dout_q   <= dout_d;
      cout_q   <= cout_d;
      exc_q    <= exc_d;
      busy_q   <= busy_d;
`ifdef ADDER_ARB_TIMEOUT_EN
      wdog_q   <= wdog_d;
`endif
    end
  end

  assign req_ack       = ack_q;
  assign rsp_dout      = dout_q;
  assign rsp_cout      = cout_q;
  assign rsp_exc       = exc_q;
  assign gnt_id        = gnt_q;
  assign busy          = busy_q;
  assign Adder_datain1 = din1_q;
  assign Adder_datain2 = din2_q;
  assign Adder_valid   = avalid_q;

endmodule
